aes_mask_fifo: RTL and testbench



---
 rtl/aes_fifo_pkg.sv | 21 ++
 rtl/aes_mask_fifo_if.sv | 31 +++
 rtl/group_alarm.sv | 29 ++
 rtl/aes_mask_fifo.sv | 91 +++++++++
 tb/tb_aes_mask_fifo.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/aes_fifo_pkg.sv
// Shared AES FIFO constants and a width helper used by the mask FIFO and its interface.
package aes_fifo_pkg;

    localparam int AESWidth  = 128;
    localparam int CmdWidth  = 1;
    localparam int FifoWidth = AESWidth + CmdWidth;

    // Number of bits needed to index `value` distinct items (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/aes_mask_fifo_if.sv
// Producer/consumer bundle for the AES mask FIFO; master is the environment, slave is the FIFO.
interface aes_mask_fifo_if
    import aes_fifo_pkg::*;
#(
    parameter int Width = FifoWidth,
    parameter int Depth = 64
);

    localparam int CountWidth = clog2(Depth) + 1;

    logic [Width-1:0]      InData;
    logic                  InValid;
    logic                  Full;
    logic [Width-1:0]      OutData;
    logic                  OutValid;
    logic                  OutReady;
    logic [CountWidth-1:0] Count;
    logic                  GroupDone;
    logic                  Overflow;

    modport master (
        output InData, InValid, OutReady,
        input  Full, OutData, OutValid, Count, GroupDone, Overflow
    );

    modport slave (
        input  InData, InValid, OutReady,
        output Full, OutData, OutValid, Count, GroupDone, Overflow
    );

endinterface

// File: rtl/group_alarm.sv
// Counts enabled cycles in groups of Threshold and flags the cycle that completes each group.
module group_alarm
    import aes_fifo_pkg::*;
#(
    parameter int Threshold = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Enable,
    output logic Done
);

    localparam int GcWidth = (Threshold > 1) ? clog2(Threshold) : 1;

    logic [GcWidth-1:0] groupCount;
    logic               atLast;

    assign atLast = (groupCount == GcWidth'(Threshold - 1));
    assign Done   = Enable & atLast;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            groupCount <= '0;
        end else if (Enable) begin
            groupCount <= atLast ? '0 : groupCount + 1'b1;
        end
    end

endmodule

// File: rtl/aes_mask_fifo.sv
// First-word-fall-through buffer for AES mask+command words with group alarm.
// Define AES_FIFO_OVERFLOW_CHECK_EN to build the sticky write-while-full Overflow flag.
module aes_mask_fifo
    import aes_fifo_pkg::*;
#(
    parameter int Width     = FifoWidth,
    parameter int Depth     = 64,
    parameter int Threshold = 4
) (
    input  logic           Clock,
    input  logic           Reset,
    aes_mask_fifo_if.slave fifoBus
);

    localparam int PtrWidth   = clog2(Depth);
    localparam int CountWidth = PtrWidth + 1;

    logic [Width-1:0]      mem [Depth];
    logic [PtrWidth-1:0]   rdPtr;
    logic [PtrWidth-1:0]   wrPtr;
    logic [CountWidth-1:0] count;
    logic                  full;
    logic                  outValid;
    logic                  writeAccept;
    logic                  pop;

    assign full     = (count == CountWidth'(Depth));
    assign outValid = (count != '0);

    // Reset gating keeps the alarm quiet while reset is held, even for Threshold=1.
    assign writeAccept = fifoBus.InValid & ~full & Reset;
    assign pop         = fifoBus.OutReady & outValid;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (writeAccept) wrPtr <= wrPtr + 1'b1;
            if (pop)         rdPtr <= rdPtr + 1'b1;
            case ({writeAccept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (writeAccept) mem[wrPtr] <= fifoBus.InData;
    end

    assign fifoBus.OutData  = mem[rdPtr];
    assign fifoBus.OutValid = outValid;
    assign fifoBus.Full     = full;
    assign fifoBus.Count    = count;

    group_alarm #(
        .Threshold(Threshold)
    ) groupAlarm (
        .Clock  (Clock),
        .Reset  (Reset),
        .Enable (writeAccept),
        .Done   (fifoBus.GroupDone)
    );

`ifdef AES_FIFO_OVERFLOW_CHECK_EN
    logic overflow;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            overflow <= 1'b0;
        end else if (fifoBus.InValid & full) begin
            overflow <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge Clock) begin
        if (Reset && fifoBus.InValid && full)
            $error("%t %m: write while full, word dropped", $time);
    end
`endif

    assign fifoBus.Overflow = overflow;
`else
    assign fifoBus.Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_aes_mask_fifo.sv
// Directed self-checking bench for aes_mask_fifo (Width=129, Depth=64, Threshold=4).
module tb_aes_mask_fifo;

    typedef logic [128:0] word_t;

`ifdef AES_FIFO_OVERFLOW_CHECK_EN
    localparam logic OvfExp = 1'b1;
`else
    localparam logic OvfExp = 1'b0;
`endif

    logic Clock;
    logic Reset;
    int   checks;
    int   errors;

    aes_mask_fifo_if bus ();

    aes_mask_fifo dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .fifoBus (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic word_t mkWord(input int i);
        return {i[0], 64'(i * 3), 64'(i)};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b0;
        bus.InData   = '0;
        Reset        = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
    endtask

    task automatic write_words(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            bus.InData  = mkWord(first + i);
            bus.InValid = 1'b1;
            tick();
        end
        bus.InValid = 1'b0;
    endtask

    task automatic test_reset();
        Reset        = 1'b0;
        bus.OutReady = 1'b1;
        bus.InValid  = 1'b1;
        bus.InData   = mkWord(1);
        #2;
        checks++; if (bus.OutValid !== 1'b0) begin errors++; $display("FAIL rst_outvalid got %b exp 0", bus.OutValid); end
        checks++; if (bus.Full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", bus.Full); end
        checks++; if (bus.GroupDone !== 1'b0) begin errors++; $display("FAIL rst_groupdone got %b exp 0", bus.GroupDone); end
        checks++; if (bus.Count !== 7'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.Count); end
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b0;
        tick();
        Reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++; if (bus.OutValid !== 1'b0) begin errors++; $display("FAIL idle_outvalid cyc %0d got %b exp 0", c, bus.OutValid); end
            checks++; if (bus.Full !== 1'b0) begin errors++; $display("FAIL idle_full cyc %0d got %b exp 0", c, bus.Full); end
            checks++; if (bus.Count !== 7'd0) begin errors++; $display("FAIL idle_count cyc %0d got %0d exp 0", c, bus.Count); end
            checks++; if (bus.GroupDone !== 1'b0) begin errors++; $display("FAIL idle_groupdone cyc %0d got %b exp 0", c, bus.GroupDone); end
            checks++; if (bus.Overflow !== 1'b0) begin errors++; $display("FAIL idle_overflow cyc %0d got %b exp 0", c, bus.Overflow); end
        end
    endtask

    task automatic test_basic();
        do_reset();
        checks++; if (bus.OutValid !== 1'b0) begin errors++; $display("FAIL basic_pre_outvalid got %b exp 0", bus.OutValid); end
        for (int i = 1; i <= 3; i++) begin
            bus.InData  = word_t'(i);
            bus.InValid = 1'b1;
            tick();
            checks++; if (bus.Count !== 7'(i)) begin errors++; $display("FAIL basic_wcount %0d got %0d exp %0d", i, bus.Count, i); end
            checks++; if (bus.OutValid !== 1'b1) begin errors++; $display("FAIL basic_outvalid %0d got %b exp 1", i, bus.OutValid); end
            checks++; if (bus.OutData !== word_t'(1)) begin errors++; $display("FAIL basic_head %0d got %h exp 1", i, bus.OutData); end
        end
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            checks++; if (bus.OutData !== word_t'(i)) begin errors++; $display("FAIL basic_pop_data %0d got %h exp %h", i, bus.OutData, word_t'(i)); end
            tick();
            checks++; if (bus.Count !== 7'(3 - i)) begin errors++; $display("FAIL basic_pcount %0d got %0d exp %0d", i, bus.Count, 3 - i); end
        end
        bus.OutReady = 1'b0;
        checks++; if (bus.OutValid !== 1'b0) begin errors++; $display("FAIL basic_empty got %b exp 0", bus.OutValid); end
    endtask

    task automatic test_full();
        do_reset();
        write_words(0, 64);
        checks++; if (bus.Full !== 1'b1) begin errors++; $display("FAIL full_flag got %b exp 1", bus.Full); end
        checks++; if (bus.Count !== 7'd64) begin errors++; $display("FAIL full_count got %0d exp 64", bus.Count); end
        bus.InData   = word_t'(129'hDEAD);
        bus.InValid  = 1'b1;
        bus.OutReady = 1'b1;
        #1;
        checks++; if (bus.GroupDone !== 1'b0) begin errors++; $display("FAIL full_drop_gd got %b exp 0", bus.GroupDone); end
        checks++; if (bus.OutData !== mkWord(0)) begin errors++; $display("FAIL full_head got %h exp %h", bus.OutData, mkWord(0)); end
        tick();
        bus.InValid = 1'b0;
        checks++; if (bus.Count !== 7'd63) begin errors++; $display("FAIL full_drop_count got %0d exp 63", bus.Count); end
        checks++; if (bus.Full !== 1'b0) begin errors++; $display("FAIL full_after_pop got %b exp 0", bus.Full); end
        checks++; if (bus.Overflow !== OvfExp) begin errors++; $display("FAIL full_overflow got %b exp %b", bus.Overflow, OvfExp); end
        for (int i = 1; i < 64; i++) begin
            checks++; if (bus.OutData !== mkWord(i)) begin errors++; $display("FAIL full_drain %0d got %h exp %h", i, bus.OutData, mkWord(i)); end
            tick();
        end
        bus.OutReady = 1'b0;
        checks++; if (bus.OutValid !== 1'b0) begin errors++; $display("FAIL full_drained got %b exp 0", bus.OutValid); end
        checks++; if (bus.Overflow !== OvfExp) begin errors++; $display("FAIL full_ovf_sticky got %b exp %b", bus.Overflow, OvfExp); end
    endtask

    task automatic test_group();
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            bus.InData  = mkWord(k);
            bus.InValid = 1'b1;
            #1;
            checks++; if (bus.GroupDone !== ((k == 4) || (k == 8))) begin errors++; $display("FAIL group_write %0d got %b exp %b", k, bus.GroupDone, (k == 4) || (k == 8)); end
            tick();
        end
        bus.InValid = 1'b0;
        write_words(100, 54);
        bus.OutReady = 1'b1;
        tick(); tick(); tick();
        bus.OutReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.InData  = mkWord(200 + k);
            bus.InValid = 1'b1;
            #1;
            checks++; if (bus.GroupDone !== 1'b0) begin errors++; $display("FAIL group_refill %0d got %b exp 0", k, bus.GroupDone); end
            tick();
        end
        checks++; if (bus.Full !== 1'b1) begin errors++; $display("FAIL group_full got %b exp 1", bus.Full); end
        #1;
        checks++; if (bus.GroupDone !== 1'b0) begin errors++; $display("FAIL group_dropped got %b exp 0", bus.GroupDone); end
        tick();
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b1;
        tick();
        bus.OutReady = 1'b0;
        bus.InValid  = 1'b1;
        #1;
        checks++; if (bus.GroupDone !== 1'b1) begin errors++; $display("FAIL group_after_drop got %b exp 1", bus.GroupDone); end
        tick();
        bus.InValid = 1'b0;
        checks++; if (bus.Count !== 7'd64) begin errors++; $display("FAIL group_count got %0d exp 64", bus.Count); end
    endtask

    task automatic test_back_to_back();
        word_t q[$];
        int    seq;
        do_reset();
        for (int i = 0; i < 5; i++) q.push_back(mkWord(1000 + i));
        write_words(1000, 5);
        seq = 1005;
        bus.InValid  = 1'b1;
        bus.OutReady = 1'b1;
        for (int c = 0; c < 200; c++) begin
            bus.InData = mkWord(seq);
            checks++; if (bus.OutData !== q[0]) begin errors++; $display("FAIL b2b_data cyc %0d got %h exp %h", c, bus.OutData, q[0]); end
            tick();
            void'(q.pop_front());
            q.push_back(mkWord(seq));
            seq++;
            checks++; if (bus.Count !== 7'd5) begin errors++; $display("FAIL b2b_count cyc %0d got %0d exp 5", c, bus.Count); end
        end
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        write_words(500, 20);
        checks++; if (bus.Count !== 7'd20) begin errors++; $display("FAIL mid_count got %0d exp 20", bus.Count); end
        #3;
        Reset = 1'b0;
        #1;
        checks++; if (bus.OutValid !== 1'b0) begin errors++; $display("FAIL mid_outvalid got %b exp 0", bus.OutValid); end
        checks++; if (bus.Count !== 7'd0) begin errors++; $display("FAIL mid_rcount got %0d exp 0", bus.Count); end
        tick();
        Reset = 1'b1;
        bus.InData  = mkWord(77);
        bus.InValid = 1'b1;
        tick();
        bus.InValid = 1'b0;
        checks++; if (bus.OutValid !== 1'b1) begin errors++; $display("FAIL mid_new_valid got %b exp 1", bus.OutValid); end
        checks++; if (bus.OutData !== mkWord(77)) begin errors++; $display("FAIL mid_new_data got %h exp %h", bus.OutData, mkWord(77)); end
        checks++; if (bus.Count !== 7'd1) begin errors++; $display("FAIL mid_new_count got %0d exp 1", bus.Count); end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        Reset        = 1'b0;
        bus.InValid  = 1'b0;
        bus.OutReady = 1'b0;
        bus.InData   = '0;
        test_reset();
        test_basic();
        test_full();
        test_group();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
